led_countdown_bar: RTL

LED_COUNTDOWN_BAR -- requirements
Module: led_countdown_bar

---
 rtl/led_countdown_bar_pkg.sv | 12 +
 rtl/led_tick_gen.sv | 33 +++
 rtl/led_countdown_bar.sv | 99 +++++++++
 3 files changed

// File: rtl/led_countdown_bar_pkg.sv
// Shared types and constants for the LED countdown bar.
// State encoding and the default step divider.
package led_countdown_bar_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam int TICK_DIV_DEF = 133_333_333;

endpackage

// File: rtl/led_tick_gen.sv
// Step-rate divider: pulses tick on the last cycle of each period.
// Counting freezes while en is low; clr restarts the period.
module led_tick_gen
   import led_countdown_bar_pkg::*;
#(
   parameter int TICK_DIV = TICK_DIV_DEF
) (
   input  logic CLOCK,
   input  logic RESETN,
   input  logic en,
   input  logic clr,
   output logic tick
);

   localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] CMAX = CW'(TICK_DIV - 1);

   logic [CW-1:0] cnt;

   assign tick = en && (cnt == CMAX);

   always_ff @(posedge CLOCK) begin
      if (!RESETN) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en) begin
         if (cnt == CMAX) cnt <= '0;
         else             cnt <= cnt + CW'(1);
      end
   end

endmodule

// File: rtl/led_countdown_bar.sv
// LED bar countdown: loads bits 0..T, extinguishes one per step.
// Abort beats start, start beats a coinciding step.
module led_countdown_bar
   import led_countdown_bar_pkg::*;
#(
   parameter  int N_LED    = 16,
   parameter  int TICK_DIV = TICK_DIV_DEF,
   localparam int IDXW     = $clog2(N_LED)
) (
   input  logic              CLOCK,
   input  logic              RESETN,
   input  logic              start,
   input  logic              abort,
   input  logic              pause,
   input  logic [IDXW-1:0]   top_idx,
   input  logic              mode,
   output logic [N_LED-1:0]  led,
   output logic              active,
   output logic [IDXW:0]     remaining,
   output logic              done
);

   localparam logic [IDXW-1:0] TMAX = IDXW'(N_LED - 1);
   localparam logic [IDXW:0]   ONE  = (IDXW+1)'(1);

   state_t              state;
   logic                mode_q;
   logic [IDXW-1:0]     t_q;
   logic [IDXW-1:0]     t_in;
   logic                tick;
   logic                en;
   logic [N_LED-1:0]    load_mask;
   logic [N_LED-1:0]    step_mask;
   logic [IDXW:0]       clr_idx;

   assign en = (state == RUN) && !pause;

   led_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
      .CLOCK  (CLOCK),
      .RESETN (RESETN),
      .en     (en),
      .clr    (start | abort),
      .tick   (tick)
   );

   always_comb begin
      t_in = (top_idx > TMAX) ? TMAX : top_idx;
      clr_idx = mode_q ? ({1'b0, t_q} + ONE - remaining)
                       : (remaining - ONE);
      load_mask = '0;
      step_mask = '0;
      for (int i = 0; i < N_LED; i++) begin
         load_mask[i] = ((IDXW+1)'(i) <= {1'b0, t_in});
         step_mask[i] = led[i] && (clr_idx != (IDXW+1)'(i));
      end
   end

   always_ff @(posedge CLOCK) begin
      if (!RESETN) begin
         state     <= IDLE;
         led       <= '0;
         remaining <= '0;
         active    <= 1'b0;
         done      <= 1'b0;
         mode_q    <= 1'b0;
         t_q       <= '0;
      end else begin
         done <= 1'b0;
         if (abort) begin
            if (state == RUN) begin
               state     <= IDLE;
               led       <= '0;
               remaining <= '0;
               active    <= 1'b0;
            end
         end else if (start) begin
            state     <= RUN;
            led       <= load_mask;
            remaining <= {1'b0, t_in} + ONE;
            active    <= 1'b1;
            mode_q    <= mode;
            t_q       <= t_in;
         end else if ((state == RUN) && tick) begin
            // Final step drains the bar and hands back to IDLE
            if (remaining == ONE) begin
               state     <= IDLE;
               led       <= '0;
               remaining <= '0;
               active    <= 1'b0;
               done      <= 1'b1;
            end else begin
               led       <= step_mask;
               remaining <= remaining - ONE;
            end
         end
      end
   end

endmodule
